// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter stage and its checker.
// Holds the checker state encoding and the Gray-to-binary decoder.
package gray_pkg;

   localparam int GRAY_W = 3;
   localparam int MAX_W  = 32;

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_TRACK = 2'd1,
      S_FAULT = 2'd2
   } state_e;

   // Narrower codes are zero-extended; leading zeros decode to zeros.
   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
      logic [MAX_W-1:0] b;
      b[MAX_W-1] = g[MAX_W-1];
      for (int i = MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/gray_seq_checker.sv
// Decodes sampled Gray codes to binary and checks for legal +1 steps,
// genuine overflow wraps and a sticky overflow flag.
module gray_seq_checker
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_W,
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic             Clr,
   input  logic [WIDTH-1:0] Gray,
   input  logic             Overflow,
   output logic [WIDTH-1:0] Bin,
   output logic             Valid,
   output logic             Step,
   output logic             Err,
   output logic [CNT_W-1:0] WrapCnt,
   output logic [CNT_W-1:0] ErrCnt
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] prev_bin_q, prev_bin_d;
   logic             prev_ovf_q, prev_ovf_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic             valid_q, valid_d;
   logic             step_q, step_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] nxt;
   logic             is_hold, is_inc, is_wrap;
   logic             ovf_bad, fault;
   logic             wrap_inc, err_inc;

   assign cur     = WIDTH'(gray2bin(MAX_W'(Gray)));
   assign nxt     = prev_bin_q + WIDTH'(1);
   assign is_hold = (cur == prev_bin_q);
   assign is_inc  = (cur == nxt);
   assign is_wrap = is_inc && (prev_bin_q == '1);
   // Overflow may only rise on the wrap itself and may never fall.
   assign ovf_bad = (!prev_ovf_q && Overflow && !is_wrap)
                 || (prev_ovf_q && !Overflow);
   assign fault   = (!is_hold && !is_inc) || ovf_bad;

   always_comb begin
      state_d    = state_q;
      prev_bin_d = prev_bin_q;
      prev_ovf_d = prev_ovf_q;
      bin_d      = bin_q;
      valid_d    = valid_q;
      step_d     = 1'b0;
      err_d      = err_q;
      wrap_inc   = 1'b0;
      err_inc    = 1'b0;
      if (Clr) begin
         state_d = S_INIT;
         valid_d = 1'b0;
         err_d   = 1'b0;
      end else if (En) begin
         bin_d      = cur;
         prev_bin_d = cur;
         prev_ovf_d = Overflow;
         unique case (state_q)
            S_INIT: begin
               valid_d = 1'b1;
               state_d = S_TRACK;
            end
            S_TRACK: begin
               if (fault) begin
                  err_d   = 1'b1;
                  err_inc = 1'b1;
                  state_d = S_FAULT;
               end else begin
                  step_d   = is_inc;
                  wrap_inc = is_wrap;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= S_INIT;
         prev_bin_q <= '0;
         prev_ovf_q <= 1'b0;
         bin_q      <= '0;
         valid_q    <= 1'b0;
         step_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_bin_q <= prev_bin_d;
         prev_ovf_q <= prev_ovf_d;
         bin_q      <= bin_d;
         valid_q    <= valid_d;
         step_q     <= step_d;
         err_q      <= err_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_wrap_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .inc   (wrap_inc),
      .clr   (Clr),
      .cnt   (WrapCnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .inc   (err_inc),
      .clr   (Clr),
      .cnt   (ErrCnt)
   );

   assign Bin   = bin_q;
   assign Valid = valid_q;
   assign Step  = step_q;
   assign Err   = err_q;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Bench for gray_seq_checker: vector table, directed corner cases and
// random stimulus against a behavioural model.
module tb_gray_seq_checker;

   logic       clk;
   logic       Reset;
   logic       En;
   logic       Clr;
   logic [2:0] Gray;
   logic       Overflow;

   logic [2:0] Bin;
   logic       Valid, Step, Err;
   logic [7:0] WrapCnt, ErrCnt;

   logic [2:0] Bin2;
   logic       Valid2, Step2, Err2;
   logic [1:0] WrapCnt2, ErrCnt2;

   int checks = 0;
   int errors = 0;

   gray_seq_checker #(.WIDTH(3), .CNT_W(8)) dut (
      .Clk(clk), .Reset(Reset), .En(En), .Clr(Clr),
      .Gray(Gray), .Overflow(Overflow),
      .Bin(Bin), .Valid(Valid), .Step(Step), .Err(Err),
      .WrapCnt(WrapCnt), .ErrCnt(ErrCnt)
   );

   gray_seq_checker #(.WIDTH(3), .CNT_W(2)) dut2 (
      .Clk(clk), .Reset(Reset), .En(En), .Clr(Clr),
      .Gray(Gray), .Overflow(Overflow),
      .Bin(Bin2), .Valid(Valid2), .Step(Step2), .Err(Err2),
      .WrapCnt(WrapCnt2), .ErrCnt(ErrCnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model
   int m_bin, m_valid, m_step, m_err, m_wrap, m_errc, m_wrap2, m_errc2;
   bit m_seen, m_fault, m_pov;
   int m_prev;

   function automatic int dec(input int g);
      int b;
      b = g;
      for (int s = 1; s < 3; s++) b = b ^ (g >> s);
      return b & 7;
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v < mx) ? v + 1 : mx;
   endfunction

   task automatic model_reset();
      m_bin = 0; m_valid = 0; m_step = 0; m_err = 0;
      m_wrap = 0; m_errc = 0; m_wrap2 = 0; m_errc2 = 0;
      m_seen = 0; m_fault = 0; m_pov = 0; m_prev = 0;
   endtask

   task automatic model_edge(input bit en, input bit clr,
                             input int g, input bit ovf);
      int  cur;
      bit  legal, wrap, bad;
      m_step = 0;
      if (clr) begin
         m_seen = 0; m_fault = 0; m_err = 0; m_valid = 0;
         m_wrap = 0; m_errc = 0; m_wrap2 = 0; m_errc2 = 0;
      end else if (en) begin
         cur = dec(g);
         m_bin = cur;
         if (!m_seen) begin
            m_seen = 1;
            m_valid = 1;
         end else if (!m_fault) begin
            legal = (cur == (m_prev + 1) % 8);
            wrap = (m_prev == 7) && (cur == 0);
            bad = !(cur == m_prev || legal)
               || (ovf && !m_pov && !wrap)
               || (!ovf && m_pov);
            if (bad) begin
               m_fault = 1;
               m_err = 1;
               m_errc = sat(m_errc, 255);
               m_errc2 = sat(m_errc2, 3);
            end else begin
               m_step = legal;
               if (wrap) begin
                  m_wrap = sat(m_wrap, 255);
                  m_wrap2 = sat(m_wrap2, 3);
               end
            end
         end
         m_prev = cur;
         m_pov = ovf;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("bin", int'(Bin), m_bin);
      chk("valid", int'(Valid), m_valid);
      chk("step", int'(Step), m_step);
      chk("err", int'(Err), m_err);
      chk("wrapcnt", int'(WrapCnt), m_wrap);
      chk("errcnt", int'(ErrCnt), m_errc);
      chk("wrapcnt2", int'(WrapCnt2), m_wrap2);
      chk("errcnt2", int'(ErrCnt2), m_errc2);
   endtask

   task automatic cyc(input bit en, input bit clr,
                      input logic [2:0] g, input bit ovf);
      @(negedge clk);
      En = en; Clr = clr; Gray = g; Overflow = ovf;
      @(posedge clk);
      model_edge(en, clr, int'(g), ovf);
      #1;
   endtask

   task automatic cyc_m(input bit en, input bit clr,
                        input logic [2:0] g, input bit ovf);
      cyc(en, clr, g, ovf);
      check_model();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      Reset = 1'b0;
      En = 1'b0; Clr = 1'b0;
      #1;
      chk("arst_bin", int'(Bin), 0);
      chk("arst_valid", int'(Valid), 0);
      chk("arst_step", int'(Step), 0);
      chk("arst_err", int'(Err), 0);
      chk("arst_wrap", int'(WrapCnt), 0);
      chk("arst_errc", int'(ErrCnt), 0);
      chk("arst_wrap2", int'(WrapCnt2), 0);
      model_reset();
      @(negedge clk);
      Reset = 1'b1;
   endtask

   typedef struct {
      bit         en;
      bit         clr;
      logic [2:0] g;
      bit         ovf;
      int         bin;
      int         valid;
      int         step;
      int         err;
      int         wrap;
      int         errc;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int gb;
      bit gov, en, clr;
      int r, k;

      tbl.push_back('{1, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 3'b001, 0, 1, 1, 1, 0, 0, 0});
      tbl.push_back('{1, 0, 3'b011, 0, 2, 1, 1, 0, 0, 0});
      tbl.push_back('{1, 0, 3'b010, 0, 3, 1, 1, 0, 0, 0});
      tbl.push_back('{1, 0, 3'b110, 0, 4, 1, 1, 0, 0, 0});
      tbl.push_back('{1, 0, 3'b111, 0, 5, 1, 1, 0, 0, 0});
      tbl.push_back('{1, 0, 3'b101, 0, 6, 1, 1, 0, 0, 0});
      tbl.push_back('{1, 0, 3'b100, 0, 7, 1, 1, 0, 0, 0});
      tbl.push_back('{1, 0, 3'b000, 1, 0, 1, 1, 0, 1, 0});
      tbl.push_back('{1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 3'b011, 0, 2, 1, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 3'b011, 0, 2, 1, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 3'b011, 0, 2, 1, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 3'b110, 0, 2, 1, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 3'b010, 0, 3, 1, 1, 0, 0, 0});

      Reset = 1'b0; En = 1'b0; Clr = 1'b0; Gray = '0; Overflow = 1'b0;
      model_reset();
      #15;
      check_model();
      #5;
      Reset = 1'b1;

      foreach (tbl[i]) begin
         cyc(tbl[i].en, tbl[i].clr, tbl[i].g, tbl[i].ovf);
         chk($sformatf("tbl%0d_bin", i), int'(Bin), tbl[i].bin);
         chk($sformatf("tbl%0d_valid", i), int'(Valid), tbl[i].valid);
         chk($sformatf("tbl%0d_step", i), int'(Step), tbl[i].step);
         chk($sformatf("tbl%0d_err", i), int'(Err), tbl[i].err);
         chk($sformatf("tbl%0d_wrap", i), int'(WrapCnt), tbl[i].wrap);
         chk($sformatf("tbl%0d_errc", i), int'(ErrCnt), tbl[i].errc);
      end

      // Illegal jump 1 -> 3, then suspended checking
      do_reset();
      cyc_m(1, 0, 3'b001, 0);
      cyc_m(1, 0, 3'b010, 0);
      chk("jump_err", int'(Err), 1);
      chk("jump_errc", int'(ErrCnt), 1);
      cyc_m(1, 0, 3'b110, 0);
      cyc_m(1, 0, 3'b111, 0);
      chk("fault_bin", int'(Bin), 5);
      chk("fault_step", int'(Step), 0);
      chk("fault_errc", int'(ErrCnt), 1);

      // Backward step 2 -> 1
      cyc_m(1, 1, 3'b000, 0);
      cyc_m(1, 0, 3'b011, 0);
      cyc_m(1, 0, 3'b001, 0);
      chk("back_err", int'(Err), 1);

      // Overflow rising without a wrap
      cyc_m(1, 1, 3'b000, 0);
      cyc_m(1, 0, 3'b000, 0);
      cyc_m(1, 0, 3'b001, 0);
      cyc_m(1, 0, 3'b011, 1);
      chk("ovfrise_err", int'(Err), 1);
      chk("ovfrise_errc", int'(ErrCnt), 1);
      chk("ovfrise_wrap", int'(WrapCnt), 0);

      // Overflow falling after a legal wrap
      cyc_m(1, 1, 3'b000, 0);
      for (int i = 0; i < 9; i++) begin
         gb = i % 8;
         cyc_m(1, 0, 3'(gb ^ (gb >> 1)), i == 8);
      end
      chk("wrap_ok", int'(WrapCnt), 1);
      cyc_m(1, 0, 3'b001, 0);
      chk("ovffall_err", int'(Err), 1);

      // Clr beats a simultaneous sample
      cyc_m(1, 1, 3'b110, 1);
      chk("clr_err", int'(Err), 0);
      chk("clr_valid", int'(Valid), 0);
      chk("clr_wrap", int'(WrapCnt), 0);
      chk("clr_errc", int'(ErrCnt), 0);
      chk("clr_bin", int'(Bin), 1);
      cyc_m(1, 0, 3'b111, 1);
      chk("clr_first_bin", int'(Bin), 5);
      chk("clr_first_err", int'(Err), 0);
      chk("clr_first_step", int'(Step), 0);

      // Five wraps: 8-bit counter reaches 5, 2-bit counter saturates
      cyc_m(1, 1, 3'b000, 0);
      for (int i = 0; i <= 40; i++) begin
         gb = i % 8;
         cyc_m(1, 0, 3'(gb ^ (gb >> 1)), i >= 8);
      end
      chk("sat_wrap2", int'(WrapCnt2), 3);
      chk("sat_wrap", int'(WrapCnt), 5);
      chk("sat_err", int'(Err), 0);

      do_reset();

      // Random stimulus
      gb = 0;
      gov = 0;
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 99);
         en = (r < 85);
         clr = (r >= 97) || (m_fault && $urandom_range(0, 9) == 0);
         k = $urandom_range(0, 99);
         if (k < 72) begin
            gb = (gb + 1) % 8;
            if (gb == 0) gov = 1;
         end else if (k >= 87) begin
            gb = $urandom_range(0, 7);
         end
         if ($urandom_range(0, 49) == 0) gov = !gov;
         if (clr && $urandom_range(0, 1) == 1) gov = 0;
         cyc_m(en, clr, 3'(gb ^ (gb >> 1)), gov);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
